duty_scale_sequencer: RTL and testbench

Time-shares the single 8x8 multiplier between the four colour channels. It scales red, green, blue and white by the global intensity and publishes all four PWM duties atomically. It sits between the deserializer outputs (colour bytes, intensity) and the PWM generator. It owns the multiplier's load/ready handshake and detects a hung multiplier.

---
 rtl/duty_scale_sequencer_if.sv | 24 ++
 rtl/duty_scale_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_duty_scale_sequencer.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/duty_scale_sequencer_if.sv
// Multiplier handshake between the duty scaler (master) and the shared 8x8 multiplier (slave).
interface duty_scale_sequencer_if;
    logic [7:0]  mult_a;
    logic [7:0]  mult_b;
    logic        mult_ld;
    logic        mult_rdy;
    logic [15:0] mult_res;

    modport master (
        output mult_a,
        output mult_b,
        output mult_ld,
        input  mult_rdy,
        input  mult_res
    );

    modport slave (
        input  mult_a,
        input  mult_b,
        input  mult_ld,
        output mult_rdy,
        output mult_res
    );
endinterface

// File: rtl/duty_scale_sequencer.sv
// Scales four colour bytes by a global intensity on one shared multiplier, publishing all duties at once.
// Optional SEQ_PENDING_EN: a start seen while busy queues exactly one follow-on frame.
module duty_scale_sequencer #(
    parameter int TIMEOUT = 31
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [7:0]                    lint,
    input  logic [7:0]                    red_in,
    input  logic [7:0]                    green_in,
    input  logic [7:0]                    blue_in,
    input  logic [7:0]                    white_in,
    duty_scale_sequencer_if.master        mult,
    output logic [7:0]                    red_duty,
    output logic [7:0]                    green_duty,
    output logic [7:0]                    blue_duty,
    output logic [7:0]                    white_duty,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    logic [1:0] state_reg;
    logic [1:0] ch_reg;
    logic [7:0] tmo_reg;
    logic [7:0] a_reg;
    logic [7:0] b_reg;
    logic       ld_reg;
    logic       busy_reg;
    logic       done_reg;
    logic       err_reg;

    logic [7:0] colour_in  [4];
    logic [7:0] snap_reg   [4];
    logic [7:0] scaled_reg [3];
    logic [7:0] duty_reg   [4];

    logic       pending_q;
    logic       frame_go;
    logic       wait_hit;
    logic       last_hit;
    logic [1:0] ch_inc;
    logic [7:0] scaled_now;

    assign colour_in[0] = red_in;
    assign colour_in[1] = green_in;
    assign colour_in[2] = blue_in;
    assign colour_in[3] = white_in;

    assign frame_go = (state_reg == ST_IDLE) && (start || pending_q);
    assign wait_hit = (state_reg == ST_WAIT) && mult.mult_rdy;
    assign last_hit = wait_hit && (ch_reg == 2'd3);
    assign ch_inc   = ch_reg + 2'd1;

    // Adding the colour once turns colour*lint into colour*(lint+1), so lint=255 is unity gain.
    assign scaled_now = 8'((mult.mult_res + {8'b0, a_reg}) >> 8);

`ifdef SEQ_PENDING_EN
    logic pending_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_reg <= 1'b0;
        end else if (frame_go) begin
            pending_reg <= 1'b0;
        end else if (start && (state_reg != ST_IDLE)) begin
            pending_reg <= 1'b1;
        end
    end

    assign pending_q = pending_reg;
`else
    assign pending_q = 1'b0;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_snap
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    snap_reg[gi] <= 8'd0;
                end else if (frame_go) begin
                    snap_reg[gi] <= colour_in[gi];
                end
            end
        end

        for (gi = 0; gi < 3; gi++) begin : g_scaled
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    scaled_reg[gi] <= 8'd0;
                end else if (wait_hit && (ch_reg == 2'(gi))) begin
                    scaled_reg[gi] <= scaled_now;
                end
            end
        end

        // White is the last channel, so its product goes straight to the duty register.
        for (gi = 0; gi < 4; gi++) begin : g_duty
            if (gi < 3) begin : g_mid
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        duty_reg[gi] <= 8'd0;
                    end else if (last_hit) begin
                        duty_reg[gi] <= scaled_reg[gi];
                    end
                end
            end else begin : g_last
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        duty_reg[gi] <= 8'd0;
                    end else if (last_hit) begin
                        duty_reg[gi] <= scaled_now;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            ch_reg    <= 2'd0;
            tmo_reg   <= 8'd0;
            a_reg     <= 8'd0;
            b_reg     <= 8'd0;
            ld_reg    <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            ld_reg   <= 1'b0;
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (frame_go) begin
                        state_reg <= ST_LOAD;
                        ch_reg    <= 2'd0;
                        err_reg   <= 1'b0;
                        a_reg     <= colour_in[0];
                        b_reg     <= lint;
                        ld_reg    <= 1'b1;
                        busy_reg  <= 1'b1;
                    end else begin
                        busy_reg  <= 1'b0;
                    end
                end
                // A ready seen here could belong to the previous operand, so it is not sampled.
                ST_LOAD: begin
                    state_reg <= ST_WAIT;
                    tmo_reg   <= 8'd0;
                end
                ST_WAIT: begin
                    if (mult.mult_rdy) begin
                        if (ch_reg != 2'd3) begin
                            ch_reg    <= ch_inc;
                            a_reg     <= snap_reg[ch_inc];
                            ld_reg    <= 1'b1;
                            state_reg <= ST_LOAD;
                        end else begin
                            done_reg  <= 1'b1;
                            busy_reg  <= pending_q;
                            state_reg <= ST_IDLE;
                        end
                    end else if (tmo_reg == 8'(TIMEOUT - 1)) begin
                        err_reg   <= 1'b1;
                        busy_reg  <= pending_q;
                        state_reg <= ST_IDLE;
                    end else begin
                        tmo_reg   <= tmo_reg + 8'd1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign mult.mult_a  = a_reg;
    assign mult.mult_b  = b_reg;
    assign mult.mult_ld = ld_reg;

    assign red_duty   = duty_reg[0];
    assign green_duty = duty_reg[1];
    assign blue_duty  = duty_reg[2];
    assign white_duty = duty_reg[3];
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign err        = err_reg;

endmodule

// File: tb/tb_duty_scale_sequencer.sv
// Bench for duty_scale_sequencer: latency-3 multiplier model plus a scoreboard of expected duty frames.
module tb_duty_scale_sequencer;

    localparam int L       = 3;
    localparam int TIMEOUT = 31;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] lint, red_in, green_in, blue_in, white_in;
    logic [7:0] red_duty, green_duty, blue_duty, white_duty;
    logic       busy, done, err;
    logic       hang;

    int checks = 0;
    int errors = 0;
    int ld_total = 0;

    typedef struct {
        logic [3:0][7:0] d;
        int              cyc;
    } exp_t;
    exp_t sb[$];

    duty_scale_sequencer_if mif();

    duty_scale_sequencer #(.TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .lint       (lint),
        .red_in     (red_in),
        .green_in   (green_in),
        .blue_in    (blue_in),
        .white_in   (white_in),
        .mult       (mif),
        .red_duty   (red_duty),
        .green_duty (green_duty),
        .blue_duty  (blue_duty),
        .white_duty (white_duty),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Multiplier model: result and ready appear L cycles after the load cycle.
    logic [L-1:0] rdy_pipe = '0;
    logic [15:0]  res_pipe [L];
    always @(posedge clk) begin
        rdy_pipe    <= {rdy_pipe[L-2:0], mif.mult_ld};
        res_pipe[0] <= 16'(mif.mult_a) * 16'(mif.mult_b);
        for (int i = 1; i < L; i++) res_pipe[i] <= res_pipe[i-1];
        if (mif.mult_ld === 1'b1) ld_total <= ld_total + 1;
    end
    assign mif.mult_rdy = rdy_pipe[L-1] && !hang;
    assign mif.mult_res = res_pipe[L-1];

    function automatic logic [31:0] duties();
        return {white_duty, blue_duty, green_duty, red_duty};
    endfunction

    task automatic set_colours(input logic [7:0] r, g, b, w, l);
        red_in = r; green_in = g; blue_in = b; white_in = w; lint = l;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; hang = 1'b0;
        set_colours(8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        #1;
        checks++;
        if ({duties(), busy, done, err, mif.mult_ld, mif.mult_a, mif.mult_b} !== 52'd0) begin
            errors++;
            $display("FAIL reset_state: duties=%h busy=%b done=%b err=%b ld=%b a=%h b=%h, required all 0",
                     duties(), busy, done, err, mif.mult_ld, mif.mult_a, mif.mult_b);
        end
        idle(2);
        reset = 1'b0;
        idle(2);
    endtask

    // One frame: push expectation, pulse start in cycle 0, optionally zero the colours at change_at.
    task automatic run_frame(input string name, input logic [7:0] r, g, b, w, l,
                             input logic [31:0] exp_d, input int change_at);
        exp_t e, got_e;
        int n, ld0;
        logic [31:0] old;
        bit got, atomic_ok;
        set_colours(r, g, b, w, l);
        e.d = exp_d; e.cyc = 4*L + 5;
        sb.push_back(e);
        old = duties();
        ld0 = ld_total;
        start = 1'b1; n = 0;
        @(negedge clk); start = 1'b0; n = 1;
        checks++;
        if (busy !== 1'b1 || mif.mult_ld !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL %s_cycle1: busy=%b ld=%b err=%b, required 1 1 0", name, busy, mif.mult_ld, err);
        end
        got = 0; atomic_ok = 1;
        while (n < 100) begin
            if (n == change_at) set_colours(8'd0, 8'd0, 8'd0, 8'd0, l);
            if (done === 1'b1) begin got = 1; break; end
            if (duties() !== old) atomic_ok = 0;
            @(negedge clk); n++;
        end
        got_e = sb.pop_front();
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s_done: no done within 100 cycles, required cycle %0d", name, got_e.cyc);
        end else begin
            $display("%s: done cycle %0d duties r=%0d g=%0d b=%0d w=%0d", name, n,
                     red_duty, green_duty, blue_duty, white_duty);
            if (duties() !== got_e.d || n != got_e.cyc) begin
                errors++;
                $display("FAIL %s_result: duties=%h cycle=%0d, required %h cycle %0d",
                         name, duties(), n, got_e.d, got_e.cyc);
            end
        end
        checks++;
        if (busy !== 1'b0 || (ld_total - ld0) != 4 || !atomic_ok) begin
            errors++;
            $display("FAIL %s_frame: busy=%b loads=%0d atomic=%0d, required 0 4 1",
                     name, busy, ld_total - ld0, atomic_ok);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL %s_done_pulse: done=%b one cycle after, required 0", name, done);
        end
        idle(3);
    endtask

    task automatic test_full_scale();
        run_frame("full_scale", 8'd200, 8'd100, 8'd50, 8'd255, 8'd255, {8'd255, 8'd50, 8'd100, 8'd200}, -1);
    endtask

    task automatic test_half_scale();
        run_frame("half_scale", 8'd200, 8'd100, 8'd50, 8'd255, 8'd128, {8'd128, 8'd25, 8'd50, 8'd100}, -1);
    endtask

    task automatic test_zero_scale();
        run_frame("zero_scale", 8'd200, 8'd100, 8'd50, 8'd255, 8'd0, 32'd0, -1);
    endtask

    task automatic test_snapshot();
        run_frame("snapshot", 8'd200, 8'd100, 8'd50, 8'd255, 8'd255, {8'd255, 8'd50, 8'd100, 8'd200}, 2);
    endtask

    task automatic test_timeout();
        int n, err_cyc, dones;
        logic [31:0] old;
        bit busy_at_err;
        hang = 1'b1;
        set_colours(8'd9, 8'd9, 8'd9, 8'd9, 8'd0);
        old = duties();
        start = 1'b1; n = 0;
        @(negedge clk); start = 1'b0; n = 1;
        err_cyc = -1; dones = 0; busy_at_err = 1'b1;
        while (n < 45) begin
            if (done === 1'b1) dones++;
            if (err === 1'b1 && err_cyc < 0) begin err_cyc = n; busy_at_err = busy; end
            @(negedge clk); n++;
        end
        $display("timeout: err first seen cycle %0d, dones=%0d", err_cyc, dones);
        checks++;
        if (err_cyc != TIMEOUT + 2 || busy_at_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_err: err cycle=%0d busy=%b, required cycle %0d busy 0",
                     err_cyc, busy_at_err, TIMEOUT + 2);
        end
        checks++;
        if (dones != 0 || duties() !== old || err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_hold: dones=%0d duties=%h err=%b, required 0 %h 1", dones, duties(), err, old);
        end
        hang = 1'b0;
        idle(4);
        run_frame("after_timeout", 8'd10, 8'd20, 8'd30, 8'd40, 8'd255, {8'd40, 8'd30, 8'd20, 8'd10}, -1);
    endtask

    task automatic test_reset_midframe();
        int n, dones;
        bit quiet;
        set_colours(8'd77, 8'd66, 8'd55, 8'd44, 8'd255);
        start = 1'b1; n = 0;
        @(negedge clk); start = 1'b0; n = 1;
        while (n < 10) begin @(negedge clk); n++; end
        reset = 1'b1;
        #1;
        checks++;
        if ({duties(), busy, done, err, mif.mult_ld, mif.mult_a, mif.mult_b} !== 52'd0) begin
            errors++;
            $display("FAIL reset_midframe: duties=%h busy=%b ld=%b a=%h b=%h, required all 0",
                     duties(), busy, mif.mult_ld, mif.mult_a, mif.mult_b);
        end
        @(negedge clk); reset = 1'b0; n++;
        dones = 0; quiet = 1;
        while (n < 30) begin
            if (done === 1'b1) dones++;
            if (duties() !== 32'd0 || busy !== 1'b0 || mif.mult_ld !== 1'b0) quiet = 0;
            @(negedge clk); n++;
        end
        $display("reset_midframe: dones after reset=%0d quiet=%0d", dones, quiet);
        checks++;
        if (dones != 0 || !quiet) begin
            errors++;
            $display("FAIL reset_late_rdy: dones=%0d quiet=%0d, required 0 1", dones, quiet);
        end
        idle(2);
    endtask

    task automatic test_back_to_back();
        exp_t e, got_e;
        int n, dones, want;
        bit ld18, busy17, match;
        set_colours(8'd200, 8'd100, 8'd50, 8'd255, 8'd255);
        e.d = {8'd255, 8'd50, 8'd100, 8'd200};
        e.cyc = 4*L + 5;
        sb.push_back(e);
`ifdef SEQ_PENDING_EN
        e.cyc = 2*(4*L + 5);
        sb.push_back(e);
        want = 2;
`else
        want = 1;
`endif
        start = 1'b1; n = 0;
        @(negedge clk); start = 1'b0; n = 1;
        dones = 0; match = 1; ld18 = 0; busy17 = 0;
        while (n < 50) begin
            if (n == 5) start = 1'b1;
            if (n == 6) start = 1'b0;
            if (n == 17) busy17 = busy;
            if (n == 18) ld18 = mif.mult_ld;
            if (done === 1'b1) begin
                dones++;
                $display("back_to_back: done cycle %0d duties %h", n, duties());
                if (sb.size() == 0) match = 0;
                else begin
                    got_e = sb.pop_front();
                    if (duties() !== got_e.d || n != got_e.cyc) match = 0;
                end
            end
            @(negedge clk); n++;
        end
        checks++;
        if (dones != want || !match || sb.size() != 0) begin
            errors++;
            $display("FAIL back_to_back_dones: dones=%0d match=%0d left=%0d, required %0d 1 0",
                     dones, match, sb.size(), want);
        end
        checks++;
        if (ld18 !== (want == 2) || busy17 !== (want == 2)) begin
            errors++;
            $display("FAIL back_to_back_restart: ld@18=%b busy@17=%b, required %b", ld18, busy17, want == 2);
        end
        sb.delete();
    endtask

    initial begin
        for (int i = 0; i < L; i++) res_pipe[i] = 16'd0;
        test_reset();
        test_full_scale();
        test_half_scale();
        test_zero_scale();
        test_snapshot();
        test_timeout();
        test_reset_midframe();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
